// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one Fast_Adder between NREQ requesters and
// returns each 9-bit sum on a single tagged response port.

module Fast_Adder (
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] sum
);
    logic [8:0] g;
    logic [8:0] p;
    logic [8:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum = p ^ c;
    end
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid must then hold its payload stable until ready is seen.
module adder_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [8:0]        rsp_sum,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy,
    output logic [15:0]       ops_count,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, RESP = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [7:0]     op_a_q, op_a_d;
    logic [7:0]     op_b_q, op_b_d;
    logic [IDW-1:0] id_q, id_d;
    logic [8:0]     rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [15:0]    ops_count_q, ops_count_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   cand;
    logic [8:0]     add_sum;

    Fast_Adder u_fast_adder (
        .a   ({1'b0, op_a_q}),
        .b   ({1'b0, op_b_q}),
        .sum (add_sum)
    );

    // Scan from ptr upwards, wrapping at NREQ; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        ops_count_d = ops_count_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_a_d  = req_a[8*int'(grant_idx) +: 8];
                    op_b_d  = req_b[8*int'(grant_idx) +: 8];
                    id_d    = grant_idx;
                    ptr_d   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
                    state_d = ADD;
                end
            end
            ADD: begin
                rsp_sum_d = add_sum;
                rsp_id_d  = id_q;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    ops_count_d = ops_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            ops_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            ops_count_q <= ops_count_d;
        end
    end

    // Gated by reset so the grant drops immediately, not at the next edge.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found && !reset) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign ops_count = ops_count_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised and directed checks of adder_arbiter against a round-robin
// reference model held in the bench.

module tb_adder_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [8:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [15:0]       ops_count;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;
  int model_ptr = 0;
  int model_count = 0;
  logic [IDW+8:0] exp_q[$];

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy), .ops_count(ops_count),
    .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic reset_dut();
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    model_count = 0;
    exp_q.delete();
  endtask

  // reference model: first valid requester scanning from the pointer
  function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset_dut();
    req_valid = 4'b1111;
    req_a = 32'h44332211;
    req_b = 32'h88776655;
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rsp_sum !== 9'h000) begin bad++; $display("FAIL reset_rsp_sum got=%h exp=000", rsp_sum); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    total++; if (ops_count !== 16'd0) begin bad++; $display("FAIL reset_ops_count got=%0d exp=0", ops_count); end
    total++; if (clk !== 1'b0) begin bad++; $display("FAIL reset_no_edge clk=%b exp=0", clk); end
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    reset_dut();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_a[23:16] = 8'hFF;
    req_b[23:16] = 8'h01;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    total++; if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_add got ready=%b busy=%b valid=%b exp 0000/1/0", req_ready, busy, rsp_valid);
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_sum !== 9'h100 || rsp_id !== 2'd2) begin
      bad++; $display("FAIL single_rsp got v=%b sum=%h id=%0d exp 1/100/2", rsp_valid, rsp_sum, rsp_id);
    end
    @(negedge clk);
    total++; if (ops_count !== 16'd1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_count got cnt=%0d v=%b exp 1/0", ops_count, rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int w;
    logic [NREQ-1:0] exp_rdy;
    logic [IDW+8:0] e;
    reset_dut();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'(10 * i + 3);
      req_b[8*i +: 8] = 8'(200 + i);
    end
    for (int c = 0; c < 15; c++) begin
      #1;
      exp_rdy = '0;
      if (c % 3 == 0) begin
        w = model_winner(req_valid, model_ptr);
        exp_rdy[w] = 1'b1;
        exp_q.push_back({IDW'(w), 9'(10 * w + 3 + 200 + w)});
        model_ptr = (w + 1) % NREQ;
      end
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      if (c % 3 == 2) begin
        e = exp_q.pop_front();
        total++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_sum} !== e) begin
          bad++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d sum=%h exp id=%0d sum=%h", c, rsp_valid, rsp_id, rsp_sum, e[IDW+8:9], e[8:0]);
        end
      end
      @(negedge clk);
    end
    total++; if (ops_count !== 16'd5) begin bad++; $display("FAIL rr_count got=%0d exp=5", ops_count); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[15:8] = 8'h80;
    req_b[15:8] = 8'h80;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_accept got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b1101;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_add_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (rsp_valid !== 1'b1 || rsp_sum !== 9'h100 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_hold c=%0d got v=%b sum=%h id=%0d rdy=%b exp 1/100/1/0000", c, rsp_valid, rsp_sum, rsp_id, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    total++; if (rsp_valid !== 1'b1 || ops_count !== 16'd0) begin
      bad++; $display("FAIL bp_release got v=%b cnt=%0d exp 1/0", rsp_valid, ops_count);
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || ops_count !== 16'd1) begin
      bad++; $display("FAIL bp_done got v=%b cnt=%0d exp 0/1", rsp_valid, ops_count);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    req_a = 32'h0A0B0C0D;
    req_b = 32'h01020304;
    @(negedge clk);
    req_valid = '0;
    #2;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_count !== 16'd0) begin
      bad++; $display("FAIL mid_flush got v=%b busy=%b cnt=%0d exp 0/0/0", rsp_valid, busy, ops_count);
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_rsp got v=%b exp=0", rsp_valid); end
    req_valid = 4'b1001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 9'h011) begin
      bad++; $display("FAIL mid_rsp got v=%b id=%0d sum=%h exp 1/0/011", rsp_valid, rsp_id, rsp_sum);
    end
    @(negedge clk);
    total++; if (ops_count !== 16'd1) begin bad++; $display("FAIL mid_count got=%0d exp=1", ops_count); end
  endtask

  task automatic test_random();
    int w;
    int d;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] exp_rdy;
    logic [IDW+8:0] e;
    logic [7:0] a;
    logic [7:0] b;
    reset_dut();
    for (int n = 0; n < 1000; n++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        req_a[8*i +: 8] = 8'($urandom);
        req_b[8*i +: 8] = 8'($urandom);
      end
      req_valid = mask;
      rsp_ready = 1'b0;
      #1;
      w = model_winner(mask, model_ptr);
      exp_rdy = '0;
      exp_rdy[w] = 1'b1;
      a = req_a[8*w +: 8];
      b = req_b[8*w +: 8];
      exp_q.push_back({IDW'(w), 9'({1'b0, a} + {1'b0, b})});
      model_ptr = (w + 1) % NREQ;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, req_ready, exp_rdy); end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_sum} !== e) begin
        bad++; $display("FAIL rnd_rsp n=%0d got v=%b id=%0d sum=%h exp id=%0d sum=%h", n, rsp_valid, rsp_id, rsp_sum, e[IDW+8:9], e[8:0]);
      end
      d = $urandom_range(0, 2);
      repeat (d) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      model_count++;
      total++; if (ops_count !== 16'(model_count)) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, ops_count, model_count); end
    end
    rsp_ready = 1'b0;
    total++; if (ops_count !== 16'd1000) begin bad++; $display("FAIL rnd_final got=%0d exp=1000", ops_count); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer sharing one `Fast_Adder` instance between `NREQ` independent requesters. Each requester presents an 8-bit operand pair with a valid/ready handshake. The block grants one request at a time, registers the operands into the shared adder, captures the 9-bit sum, and returns it on a single response port tagged with the requester index. It sits between the operand-producing units and the adder datapath, and is the only instantiator of `Fast_Adder` in its subsystem.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default 2: width of the requester ID. Must equal ceil(log2(NREQ)).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: bit i means requester i presents operands.
- `req_a`  in  8*NREQ: operand A of requester i at bits [8i+7:8i].
- `req_b`  in  8*NREQ: operand B of requester i at bits [8i+7:8i].
- `req_ready`  out  NREQ: one-hot or zero; bit i high means requester i's operands are accepted this cycle.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_sum`  out  9: A+B with carry-out in bit 8.
- `rsp_id`  out  IDW: index of the requester that owns `rsp_sum`.
- `busy`  out  1: high whenever state is not IDLE.
- `ops_count`  out  16: number of completed responses; wraps from 0xFFFF to 0.

## Operation
- The FSM has three states: IDLE, ADD, RESP.
- **IDLE:**
  - If any `req_valid` bit is high, select the winner by round-robin starting at `ptr`. `req_ready[winner]` is driven combinationally in this cycle.
  - On the clock edge: latch `req_a` and `req_b` of the winner into `op_a`/`op_b`, latch the winner into `id_q`, set `ptr` to (winner+1) mod NREQ, and go to ADD.
  - If no `req_valid` bit is high, all `req_ready` bits are 0 and the FSM stays in IDLE.
- **ADD:**
  - `Fast_Adder` is driven with A = {1'b0, `op_a`} and B = {1'b0, `op_b`}.
  - On the clock edge: register the adder's sum into `rsp_sum`, copy `id_q` into `rsp_id`, and go to RESP.
- **RESP:**
  - `rsp_valid` = 1.
  - When `rsp_ready` = 1: increment `ops_count` and go to IDLE.
  - Otherwise: hold `rsp_sum`, `rsp_id` and `rsp_valid` stable and stay in RESP.
- `req_ready` is 0 in ADD and in RESP. At most one `req_ready` bit is ever high.
- Round-robin rule: the winner is the first i with `req_valid[i]` = 1, scanning i = `ptr`, `ptr`+1, ... modulo NREQ. `ptr` changes only on a grant.
- Arithmetic: `rsp_sum` must equal the 9-bit unsigned sum a+b for every 8-bit a and b. There is no carry-in.
- Requesters must hold `req_valid`, `req_a` and `req_b` stable until they see `req_ready`. Deasserting `req_valid` before the grant withdraws the request with no side effect.
- **Reset (asynchronous, also when asserted mid-operation):**
  - FSM goes to IDLE and `ptr` = 0.
  - `op_a`, `op_b`, `id_q`, `rsp_sum`, `rsp_id` = 0.
  - `rsp_valid` = 0, `busy` = 0, `ops_count` = 0, `req_ready` = 0.
  - Any in-flight operation is discarded and no response is produced for it.

## Timing
- Request accepted at edge T (`req_ready` high in the cycle before T): `rsp_valid` rises after edge T+1, i.e. 2 cycles after acceptance.
- If `rsp_ready` is held at 1, the minimum spacing between grants is 3 cycles.
- The consumer can extend the RESP state indefinitely by holding `rsp_ready` low.
- `req_ready` depends combinationally on `req_valid`, state and `ptr`. There is no combinational path from `rsp_ready` to any output.
- When the response is accepted at edge T, the next grant is issued in the IDLE cycle that follows T (no back-to-back grant on the same edge).
- `ops_count` increments on the same edge as the `rsp_valid`&`rsp_ready` handshake.
- `busy` is registered, derived from the state register only.

## Test plan
- **Reset values:** assert `reset` mid-cycle with `req_valid` = 4'b1111 → all outputs are 0 immediately, with no dependency on `clk`.
- **Single request:** requester 2 sends a = 8'hFF, b = 8'h01 with `rsp_ready` = 1 → `req_ready` = 4'b0100 in the accept cycle; 2 cycles later `rsp_valid` = 1, `rsp_sum` = 9'h100, `rsp_id` = 2; then `ops_count` = 1.
- **Round-robin fairness:** hold `req_valid` = 4'b1111 continuously after reset, with `rsp_ready` = 1 → grants in order 0, 1, 2, 3, 0, one every 3 cycles.
- **Backpressure:** requester 1 sends a = 8'h80, b = 8'h80 and `rsp_ready` is held low for 5 cycles → `rsp_valid`, `rsp_sum` = 9'h100 and `rsp_id` = 1 stay stable; `req_ready` = 0 throughout; one response is delivered when `rsp_ready` rises.
- **Reset mid-operation:** assert `reset` while in ADD → no response appears; after release, `ptr` = 0, so simultaneous requests 0 and 3 are granted to 0 first.
- **Random arithmetic:** 1000 random (a, b, requester) triples are checked against a+b and the correct `rsp_id`; `ops_count` equals 1000 at the end.
